uart_transmitter: RTL

Serial transmit end of the CPU's UART link: accepts one byte at a time over a ready/valid handshake and shifts it out on `FPGA_SERIAL_TX` as an 8N1 frame. It pairs with the existing serial receiver: one instance sits inside `Riscv151` behind the memory-mapped UART registers, and another in testbenches drives `FPGA_SERIAL_RX`. All state is in a single clock domain.

---
 rtl/uart_transmitter_pkg.sv | 13 +
 rtl/uart_transmitter.sv | 116 +++++++++++
 2 files changed

// File: rtl/uart_transmitter_pkg.sv
// rtl/uart_transmitter_pkg.sv - shared UART framing constants for the transmitter and receiver
package uart_transmitter_pkg;

  localparam int   FRAME_BITS = 10;
  localparam int   DATA_BITS  = 8;
  localparam logic LINE_IDLE  = 1'b1;

  // Cycles per bit on the line; integer division, so the baud rate is only approximated.
  function automatic int symbol_edge_time(input int clock_freq, input int baud_rate);
    return clock_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_transmitter.sv
// rtl/uart_transmitter.sv - 8N1 UART transmitter with a ready/valid byte input
// The start bit is driven from the accept edge itself, so the line has zero accept latency.
module uart_transmitter
  import uart_transmitter_pkg::*;
#(
  parameter int CLOCK_FREQ = 50_000_000,
  parameter int BAUD_RATE  = 115_200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_in,
  input  logic       data_in_valid,
  output logic       data_in_ready,
  output logic       serial_out
);

  localparam int SYMBOL_EDGE_TIME    = symbol_edge_time(CLOCK_FREQ, BAUD_RATE);
  localparam int CLOCK_COUNTER_WIDTH = $clog2(SYMBOL_EDGE_TIME);
  localparam logic [CLOCK_COUNTER_WIDTH-1:0] LAST_CYCLE =
    CLOCK_COUNTER_WIDTH'(SYMBOL_EDGE_TIME - 1);
  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_e;

  state_e                         state_q, state_d;
  logic [CLOCK_COUNTER_WIDTH-1:0] cycle_cnt_q, cycle_cnt_d;
  logic [2:0]                     bit_cnt_q, bit_cnt_d;
  logic [7:0]                     shift_q, shift_d;
  logic                           tx_q, tx_d;
  logic                           ready_q, ready_d;
  logic                           symbol_end;

  assign symbol_end    = (cycle_cnt_q == LAST_CYCLE);
  assign data_in_ready = ready_q;
  assign serial_out    = tx_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cycle_cnt_q <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      tx_q        <= LINE_IDLE;
      ready_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      cycle_cnt_q <= cycle_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      tx_q        <= tx_d;
      ready_q     <= ready_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cycle_cnt_d = symbol_end ? '0 : cycle_cnt_q + 1'b1;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    tx_d        = tx_q;
    ready_d     = ready_q;

    case (state_q)
      IDLE: begin
        cycle_cnt_d = '0;
        bit_cnt_d   = '0;
        tx_d        = LINE_IDLE;
        ready_d     = 1'b1;
        if (data_in_valid && ready_q) begin
          state_d = START;
          shift_d = data_in;
          tx_d    = 1'b0;
          ready_d = 1'b0;
        end
      end
      START: begin
        if (symbol_end) begin
          state_d   = DATA;
          bit_cnt_d = '0;
          tx_d      = shift_q[0];
        end
      end
      DATA: begin
        if (symbol_end) begin
          if (bit_cnt_q == LAST_BIT) begin
            state_d = STOP;
            tx_d    = LINE_IDLE;
          end else begin
            // Register the next bit directly so the line never sees a combinational path.
            shift_d   = shift_q >> 1;
            tx_d      = shift_q[1];
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end
      STOP: begin
        if (symbol_end) begin
          state_d = IDLE;
          tx_d    = LINE_IDLE;
          ready_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = LINE_IDLE;
        ready_d = 1'b1;
      end
    endcase
  end

endmodule
